// File: rtl/spi_byte_engine.sv
// SPI byte shifter driven by extension ctrl-write events. It shifts one byte out
// on MOSI (MSB first, mode 0) while capturing MISO, and returns RDATA and BUSY.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transfer; selects are applied immediately
// ST_LOW  | SCK low phase, MOSI holds the current bit
// ST_HIGH | SCK high phase, MISO bit already captured
// ST_DONE | one-cycle settle after the last falling edge; BUSY already low
module spi_byte_engine #(
  parameter int         CLKDIV = 1,
  parameter logic [3:0] DEV    = 4'hE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CTRL_STB,
  input  logic [15:0] CTRL_ADDR,
  input  logic [2:0]  MISO,
  output logic        MOSI,
  output logic        SCK,
  output logic [1:0]  nSS,
  output logic [7:0]  RDATA,
  output logic        BUSY
);

  localparam int             DW     = $clog2(CLKDIV) + 1;
  localparam logic [DW-1:0]  DIV_TC = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bits_q, bits_d;
  logic [7:0]    tx_q, tx_d, rx_q, rx_d, rdata_d;
  logic [1:0]    pend_q, pend_d, nss_d;
  logic          pend_vld_q, pend_vld_d;
  logic          sck_d, mosi_d, busy_d;
  logic          do_abort, do_sel, do_start, div_tc, last_edge, misox;

  assign do_abort  = CTRL_STB && (CTRL_ADDR[7:0] == 8'h7F);
  assign do_sel    = CTRL_STB && !do_abort && (CTRL_ADDR[3:2] != 2'b00);
  assign do_start  = CTRL_STB && !do_abort && (CTRL_ADDR[3:2] == 2'b00) &&
                     (CTRL_ADDR[7:4] == DEV) && !BUSY;
  assign div_tc    = (div_q == DIV_TC);
  assign last_edge = (state_q == ST_HIGH) && div_tc && (bits_q == 4'd8);
  // Device 2 is the fallback input, selected when neither nSS line is active.
  assign misox = (MISO[0] & ~nSS[0]) | (MISO[1] & ~nSS[1]) | (MISO[2] & nSS[0] & nSS[1]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bits_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
      nSS        <= 2'b11;
      RDATA      <= 8'h00;
      BUSY       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      SCK        <= sck_d;
      MOSI       <= mosi_d;
      nSS        <= nss_d;
      RDATA      <= rdata_d;
      BUSY       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = do_start ? ST_LOW : ST_IDLE;
      ST_LOW:           if (div_tc) state_d = ST_HIGH;
      ST_HIGH:          if (div_tc) state_d = (bits_q == 4'd8) ? ST_DONE : ST_LOW;
      default:          state_d = ST_IDLE;
    endcase
    if (do_abort) state_d = ST_IDLE;
  end

  always_comb begin
    div_d      = div_q;
    bits_d     = bits_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = RDATA;
    nss_d      = nSS;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    sck_d      = SCK;
    mosi_d     = MOSI;
    busy_d     = BUSY;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (do_start) begin
          busy_d = 1'b1;
          sck_d  = 1'b0;
          mosi_d = CTRL_ADDR[15];
          tx_d   = CTRL_ADDR[15:8];
          bits_d = 4'd0;
          div_d  = '0;
        end
      end
      ST_LOW: begin
        if (div_tc) begin
          sck_d  = 1'b1;
          rx_d   = {rx_q[6:0], misox};
          bits_d = bits_q + 4'd1;
          div_d  = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_tc) begin
          sck_d = 1'b0;
          div_d = '0;
          if (bits_q == 4'd8) begin
            busy_d     = 1'b0;
            mosi_d     = 1'b0;
            rdata_d    = rx_q;
            pend_vld_d = 1'b0;
            if (pend_vld_q) nss_d = pend_q;
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: ;
    endcase
    // A select arriving on the final edge is newer than anything pending, so it wins.
    if (do_sel) begin
      if (BUSY && !last_edge) begin
        pend_d     = CTRL_ADDR[3:2];
        pend_vld_d = 1'b1;
      end else begin
        nss_d = CTRL_ADDR[3:2];
      end
    end
    if (do_abort) begin
      sck_d      = 1'b0;
      mosi_d     = 1'b0;
      nss_d      = 2'b11;
      busy_d     = 1'b0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
      bits_d     = 4'd0;
      div_d      = '0;
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: two instances (CLKDIV=1 and CLKDIV=3), directed ctrl
// strobes, expected transfer outcomes queued and checked when BUSY falls.
module tb_spi_byte_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] addr;
  logic        stb   [2];
  logic        dsck  [2];
  logic        dmosi [2];
  logic        dbusy [2];
  logic [1:0]  dnss  [2];
  logic [7:0]  drdata[2];
  logic [2:0]  miso;
  logic [7:0]  miso_pat;
  logic        miso1_v, miso2_v, miso0_v;
  int          nfall = 0;

  always #5 CLK = ~CLK;

  spi_byte_engine #(.CLKDIV(1), .DEV(4'hE)) u_div1 (
    .CLK(CLK), .RST(RST), .CTRL_STB(stb[0]), .CTRL_ADDR(addr), .MISO(miso),
    .MOSI(dmosi[0]), .SCK(dsck[0]), .nSS(dnss[0]), .RDATA(drdata[0]), .BUSY(dbusy[0]));

  spi_byte_engine #(.CLKDIV(3), .DEV(4'hE)) u_div3 (
    .CLK(CLK), .RST(RST), .CTRL_STB(stb[1]), .CTRL_ADDR(addr), .MISO(miso),
    .MOSI(dmosi[1]), .SCK(dsck[1]), .nSS(dnss[1]), .RDATA(drdata[1]), .BUSY(dbusy[1]));

  // Device 0 model: presents miso_pat MSB first, advancing on each SCK fall of u_div1.
  assign miso0_v = (nfall < 8) ? miso_pat[3'(7 - nfall)] : 1'b0;
  assign miso    = {miso2_v, miso1_v, miso0_v};

  logic ps0 = 1'b0, pb0 = 1'b0;
  always @(negedge CLK) begin
    if (dbusy[0] === 1'b1 && pb0 !== 1'b1) nfall = 0;
    else if (ps0 === 1'b1 && dsck[0] === 1'b0) nfall++;
    ps0 = dsck[0];
    pb0 = dbusy[0];
  end

  typedef struct {
    int         dev;
    logic [7:0] rdata;
    logic [7:0] mosi;
    int         pulses;
    int         cycles;
    logic [1:0] nss;
    bit         full;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] rd, input logic [7:0] mo,
                      input int pu, input int cy, input logic [1:0] ns, input bit full);
    exp_t e;
    e.dev = d; e.rdata = rd; e.mosi = mo; e.pulses = pu;
    e.cycles = cy; e.nss = ns; e.full = full;
    sbq.push_back(e);
  endtask

  // Monitor: per-instance transfer statistics, checked against the queue on BUSY fall.
  logic       pbusy[2], psck[2];
  logic [1:0] pnss[2];
  logic [7:0] cap[2];
  int         cyc[2], pul[2], run[2], perr[2], gerr[2];

  task automatic check_end(input int d);
    exp_t e;
    int   div;
    div = (d == 0) ? 1 : 3;
    if (sbq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_end dev%0d: got BUSY fall, expected none", d);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("dev%0d_order", d), d, e.dev);
      chk($sformatf("dev%0d_rdata", d), drdata[d], e.rdata);
      chk($sformatf("dev%0d_sck_pulses", d), pul[d], e.pulses);
      chk($sformatf("dev%0d_nss_after", d), dnss[d], e.nss);
      chk($sformatf("dev%0d_nss_stable", d), gerr[d], 0);
      if (e.full) begin
        chk($sformatf("dev%0d_mosi_byte", d), cap[d], e.mosi);
        chk($sformatf("dev%0d_busy_cycles", d), cyc[d], e.cycles);
        chk($sformatf("dev%0d_sck_phase_errs", d), perr[d] + ((run[d] != div) ? 1 : 0), 0);
        chk($sformatf("dev%0d_mosi_idle", d), dmosi[d], 0);
      end
    end
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (dbusy[d] === 1'b1 && pbusy[d] !== 1'b1) begin
        cyc[d] = 0; pul[d] = 0; run[d] = 0; perr[d] = 0; gerr[d] = 0; cap[d] = 8'h00;
      end
      if (dbusy[d] === 1'b1) begin
        cyc[d]++;
        if (dsck[d] === 1'b1 && psck[d] === 1'b0) begin
          pul[d]++;
          cap[d] = {cap[d][6:0], dmosi[d]};
        end
        if (pbusy[d] === 1'b1 && dsck[d] === psck[d]) run[d]++;
        else begin
          if (pbusy[d] === 1'b1 && run[d] != ((d == 0) ? 1 : 3)) perr[d]++;
          run[d] = 1;
        end
        if (pbusy[d] === 1'b1 && dnss[d] !== pnss[d]) gerr[d]++;
      end
      if (dbusy[d] === 1'b0 && pbusy[d] === 1'b1) check_end(d);
      pbusy[d] = dbusy[d];
      psck[d]  = dsck[d];
      pnss[d]  = dnss[d];
    end
  end

  task automatic strobe(input int d, input logic [15:0] a);
    @(posedge CLK); #1;
    addr   = a;
    stb[d] = 1'b1;
    @(posedge CLK); #1;
    stb[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (dbusy[d] === 1'b1 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("dev%0d_done_timeout", d), dbusy[d], 0);
    @(negedge CLK);
  endtask

  task automatic chk_idle(input int d, input logic [7:0] rd);
    @(negedge CLK);
    chk($sformatf("dev%0d_idle_sck", d), dsck[d], 0);
    chk($sformatf("dev%0d_idle_mosi", d), dmosi[d], 0);
    chk($sformatf("dev%0d_idle_nss", d), dnss[d], 2'b11);
    chk($sformatf("dev%0d_idle_busy", d), dbusy[d], 0);
    chk($sformatf("dev%0d_idle_rdata", d), drdata[d], rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; addr = 16'h0000; stb[0] = 1'b0; stb[1] = 1'b0;
    miso_pat = 8'h00; miso1_v = 1'b0; miso2_v = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    chk_idle(0, 8'h00);
    chk_idle(1, 8'h00);

    // Select device 0, then a byte exchange 0xA5 out / 0x3C in at CLKDIV=1.
    strobe(0, 16'h0008);
    @(negedge CLK);
    chk("dev0_select_nss", dnss[0], 2'b10);
    miso_pat = 8'h3C;
    push(0, 8'h3C, 8'hA5, 8, 16, 2'b10, 1'b1);
    strobe(0, 16'hA5E0);
    wait_idle(0);

    // CLKDIV=3 with no device selected: fallback MISO[2] held high.
    miso2_v = 1'b1;
    push(1, 8'hFF, 8'h00, 8, 48, 2'b11, 1'b1);
    strobe(1, 16'h00E0);
    wait_idle(1);
    miso2_v = 1'b0;

    // Select and a second start while busy: select deferred, start dropped.
    miso_pat = 8'hC3;
    push(0, 8'hC3, 8'h5A, 8, 16, 2'b01, 1'b1);
    strobe(0, 16'h5AE0);
    strobe(0, 16'h0004);
    @(negedge CLK);
    chk("dev0_pending_nss_held", dnss[0], 2'b10);
    chk("dev0_busy_during", dbusy[0], 1);
    strobe(0, 16'h33E0);
    wait_idle(0);
    repeat (20) @(negedge CLK);
    chk("dev0_no_restart", dbusy[0], 0);
    chk("dev0_pending_applied", dnss[0], 2'b01);

    // Abort during the third SCK high phase, then a clean full transfer.
    push(1, 8'hFF, 8'h00, 3, 0, 2'b11, 1'b0);
    strobe(1, 16'hFFE0);
    repeat (14) @(posedge CLK);
    strobe(1, 16'h007F);
    chk_idle(1, 8'hFF);
    push(1, 8'h00, 8'h81, 8, 48, 2'b11, 1'b1);
    strobe(1, 16'h81E0);
    wait_idle(1);

    // Reset mid-transfer while a strobe is also presented: reset wins.
    push(0, 8'h00, 8'h00, 2, 0, 2'b11, 1'b0);
    strobe(0, 16'h3CE0);
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1; addr = 16'h00E0; stb[0] = 1'b1; stb[1] = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
    chk_idle(0, 8'h00);
    chk_idle(1, 8'h00);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
